// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multiply/divide sequencing controller.
// Optional watchdog is enabled with the MULTDIV_TIMEOUT_EN macro.
package multdiv_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MULT  = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam int unsigned DEFAULT_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] alu_op);
        return (opcode == OPC_RTYPE) && ((alu_op == ALU_MULT) || (alu_op == ALU_DIV));
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// BUSY-cycle counter for the multdiv controller; only instantiated when
// MULTDIV_TIMEOUT_EN is defined.
module multdiv_watchdog
    import multdiv_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic ctrl_reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds (BUSY cycle number - 1), so the start-pulse cycle reads 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for mult/div: start pulse, pipeline stall, result latch write.
// Define MULTDIV_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic [31:0] ir_in,
    input  logic        op_valid,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        latch_en,
    output logic        latch_clr,
    output logic [31:0] ir_hold,
    output logic        latch_valid,
    output logic        exception_out
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("multdiv_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic [31:0] ir_hold_q, ir_hold_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        clr_q, clr_d;
    logic        exc_q, exc_d;

    logic decode_hit, decode_div, accept, rdy_seen, timeout;

    assign decode_hit = is_multdiv(ir_in[31:27], ir_in[6:2]);
    assign decode_div = (ir_in[6:2] == ALU_DIV);
    // rdy is ignored while the start pulse is still on the wire.
    assign rdy_seen   = data_resultRDY && !(mult_q || div_q);

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .clr_i       (accept),
        .en_i        (state_q == ST_BUSY),
        .expired_o   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        ir_hold_d = ir_hold_q;
        mult_d    = 1'b0;
        div_d     = 1'b0;
        clr_d     = 1'b0;
        exc_d     = exc_q;
        accept    = 1'b0;
        stall     = 1'b0;
        latch_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid && decode_hit && !flush) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    ir_hold_d = ir_in;
                    mult_d    = !decode_div;
                    div_d     = decode_div;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    clr_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (rdy_seen) begin
                        latch_en = 1'b1;
                        exc_d    = data_exception;
                        state_d  = ST_DONE;
                    end else if (timeout) begin
                        clr_d   = 1'b1;
                        exc_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!ctrl_reset_n) begin
            stall    = 1'b0;
            latch_en = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state_q   <= ST_IDLE;
            ir_hold_q <= '0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            clr_q     <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_hold_q <= ir_hold_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            clr_q     <= clr_d;
            exc_q     <= exc_d;
        end
    end

    assign ctrl_MULT     = mult_q;
    assign ctrl_DIV      = div_q;
    assign latch_clr     = clr_q;
    assign ir_hold       = ir_hold_q;
    assign latch_valid   = (state_q == ST_DONE);
    assign exception_out = (state_q == ST_DONE) && exc_q;

endmodule
